// File: rtl/ram_burst_reader.sv
// ram_burst_reader: reads a burst of consecutive words from a single-port RAM
// with a 1-cycle synchronous read and emits them on a valid/ready stream.
//
// Stream handshake: out_valid/out_data present the FIFO head. A word moves
// only in a cycle where out_valid & out_ready are both high. Once out_valid
// is raised, it stays high and out_data stays stable until that transfer
// happens.
//
// Reads are issued only while the 2-entry FIFO plus the one possible read in
// flight, less the word leaving this cycle, is under 2. This keeps the FIFO
// from ever overflowing, even under sustained backpressure.
module ram_burst_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_address,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_CE,
  output logic                     ram_WE,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  input  logic [DATA_WIDTH-1:0]    ram_data_output,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [ADDRESS_WIDTH:0]   LEN_ONE  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH:0]   remaining;      // reads still to issue
  logic [ADDRESS_WIDTH-1:0] next_address;   // base + reads issued so far
  logic [ADDRESS_WIDTH-1:0] last_address;   // address of the most recent read
  logic                     inflight;       // a read was issued last cycle
  logic                     zero_done;      // zero-length start seen last cycle
  logic [DATA_WIDTH-1:0]    fifo_mem [2];
  logic                     rd_ptr, wr_ptr;
  logic [1:0]               fifo_count;
  logic [2:0]               occupancy;
  logic                     push, pop, issue, accept, done_fsm;

  assign fsm_state = state;
  assign accept    = (state == IDLE) && start;
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign push      = inflight;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == READ) && (occupancy < 3'd2);
  assign ram_CE      = issue;
  assign ram_WE      = 1'b0;
  assign ram_address = issue ? next_address : last_address;
  assign busy        = (state != IDLE);
  assign done        = done_fsm || zero_done;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and completion pulse
  always_comb begin
    state_next = state;
    done_fsm   = 1'b0;
    case (state)
      IDLE:  if (start && (length != '0)) state_next = READ;
      READ:  if (issue && (remaining == LEN_ONE)) state_next = DRAIN;
      DRAIN: begin
        if ((fifo_count == 2'd0) && !inflight) begin
          state_next = IDLE;
          done_fsm   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Burst bookkeeping: capture on start, advance on every issued read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining    <= '0;
      next_address <= '0;
      last_address <= '0;
      inflight     <= 1'b0;
      zero_done    <= 1'b0;
    end else begin
      inflight  <= issue;
      zero_done <= accept && (length == '0);
      if (accept) begin
        remaining    <= length;
        next_address <= base_address;
      end else if (issue) begin
        remaining    <= remaining - LEN_ONE;
        next_address <= next_address + ADDR_ONE;
        last_address <= next_address;
      end
    end
  end

  // Two-entry FIFO absorbing RAM latency and downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= ram_data_output;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
